// File: rtl/tiny_nn_pkg.sv
// Shared tiny_nn types: command opcodes and the job scheduler state encoding.
package tiny_nn_pkg;

  typedef enum logic [3:0] {
    CmdOpNop       = 4'h0,
    CmdOpLoadParam = 4'h1,
    CmdOpConvolve  = 4'h2,
    CmdOpReadAcc   = 4'h3
  } cmd_op_e;

  typedef enum logic [1:0] {
    SchIdle,
    SchParam,
    SchExec,
    SchDone
  } sched_state_e;

endpackage

// File: rtl/tiny_nn_job_sched_if.sv
// Per-requester command descriptor handshake between host command sources and the scheduler.
interface tiny_nn_job_sched_if #(
  parameter int unsigned NumReq     = 2,
  parameter int unsigned CountWidth = 12
);
  logic [NumReq-1:0]            req_valid;
  logic [NumReq-1:0]            req_ready;
  logic [NumReq*4-1:0]          req_op;
  logic [NumReq*CountWidth-1:0] req_count;

  modport master (output req_valid, req_op, req_count, input req_ready);
  modport slave  (input req_valid, req_op, req_count, output req_ready);
endinterface

// File: rtl/tiny_nn_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping to index 0.
module tiny_nn_rr_arb #(
  parameter  int unsigned NumReq = 2,
  localparam int unsigned IdW    = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdW-1:0]    ptr,
  output logic [NumReq-1:0] gnt,
  output logic [IdW-1:0]    gnt_idx,
  output logic              gnt_valid
);
  logic [NumReq-1:0] at_or_after;
  logic [NumReq-1:0] pick;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_mask
    assign at_or_after[gi] = (IdW'(gi) >= ptr);
  end

  // Prefer requesters at/after ptr; fall back to the whole vector to wrap around.
  assign pick      = |(req & at_or_after) ? (req & at_or_after) : req;
  assign gnt_valid = |req;

  always_comb begin
    gnt_idx = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (pick[i]) gnt_idx = IdW'(i);
    end
  end

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_gnt
    assign gnt[gi] = gnt_valid && (gnt_idx == IdW'(gi));
  end
endmodule

// File: rtl/tiny_nn_job_sched.sv
// Shares one tiny_nn_core between requesters: RR accept, param load, two-phase exec, completion.
// Optional performance counters are built when TINY_NN_SCHED_PERF_EN is defined.
module tiny_nn_job_sched
  import tiny_nn_pkg::*;
#(
  parameter  int unsigned NumReq         = 2,
  parameter  int unsigned CountWidth     = 12,
  parameter  int unsigned ValArrayWidth  = 4,
  parameter  int unsigned ValArrayHeight = 2,
  localparam int unsigned ValArraySize   = ValArrayWidth * ValArrayHeight,
  localparam int unsigned IdW            = $clog2(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  tiny_nn_job_sched_if.slave      req_if,
  input  logic                    abort_i,
  output logic                    param_req_o,
  output logic [ValArraySize-1:0] param_write_o,
  output logic [1:0]              val_shift_o,
  output logic                    mul_row_sel_o,
  output logic                    mul_en_o,
  output logic                    accumulate_en_o,
  output logic                    busy_o,
  output logic [IdW-1:0]          grant_id_o,
  output logic                    done_o,
  output logic [IdW-1:0]          done_id_o,
  output logic                    done_abort_o,
  output logic                    err_o,
  output logic [31:0]             perf_busy_o,
  output logic [15:0]             perf_jobs_o
);
  if (ValArrayHeight != 2) begin : g_bad_height
    $error("tiny_nn_job_sched: ValArrayHeight must be 2");
  end

  typedef struct packed {
    cmd_op_e               op;
    logic [CountWidth-1:0] count;
  } sched_req_t;

  sched_state_e            state_reg, state_next;
  logic [IdW-1:0]          ptr_reg, ptr_next;
  logic [IdW-1:0]          grant_id_reg, grant_id_next;
  logic [CountWidth-1:0]   count_reg, count_next;
  logic [ValArraySize-1:0] param_sel_reg, param_sel_next;
  logic                    phase_reg, phase_next;
  logic                    abort_flag_reg, abort_flag_next;
  logic                    err_reg, err_next;

  logic [NumReq-1:0]       arb_gnt;
  logic [IdW-1:0]          arb_idx;
  logic                    arb_valid;
  logic                    accept;
  sched_req_t              req_arr [NumReq];
  sched_req_t              sel_req;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
    assign req_arr[gi].op    = cmd_op_e'(req_if.req_op[gi*4 +: 4]);
    assign req_arr[gi].count = req_if.req_count[gi*CountWidth +: CountWidth];
  end

  tiny_nn_rr_arb #(.NumReq(NumReq)) u_arb (
    .req       (req_if.req_valid),
    .ptr       (ptr_reg),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // Ready is withheld during reset so no descriptor is consumed and then lost.
  assign accept           = (state_reg == SchIdle) && arb_valid && !rst_i;
  assign req_if.req_ready = accept ? arb_gnt : '0;
  assign sel_req          = req_arr[arb_idx];

  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    grant_id_next   = grant_id_reg;
    count_next      = count_reg;
    param_sel_next  = param_sel_reg;
    phase_next      = phase_reg;
    abort_flag_next = abort_flag_reg;
    err_next        = 1'b0;
    param_req_o     = 1'b0;
    param_write_o   = '0;
    val_shift_o     = 2'b00;
    mul_row_sel_o   = 1'b0;
    mul_en_o        = 1'b0;
    accumulate_en_o = 1'b0;
    done_o          = 1'b0;
    unique case (state_reg)
      SchIdle: begin
        if (accept) begin
          ptr_next = (arb_idx == IdW'(NumReq - 1)) ? '0 : arb_idx + IdW'(1);
          if (sel_req.op == CmdOpConvolve) begin
            grant_id_next   = arb_idx;
            count_next      = sel_req.count;
            param_sel_next  = ValArraySize'(1);
            abort_flag_next = 1'b0;
            state_next      = SchParam;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      SchParam: begin
        param_write_o = param_sel_reg;
        param_req_o   = |param_sel_reg;
        if (abort_i) begin
          abort_flag_next = 1'b1;
          state_next      = SchDone;
        end else if (param_sel_reg[ValArraySize-1]) begin
          phase_next = 1'b0;
          state_next = SchExec;
        end else begin
          param_sel_next = param_sel_reg << 1;
        end
      end
      SchExec: begin
        val_shift_o     = {phase_reg, ~phase_reg};
        mul_row_sel_o   = phase_reg;
        mul_en_o        = 1'b1;
        accumulate_en_o = phase_reg;
        phase_next      = ~phase_reg;
        // Abort takes priority over the final exec cycle.
        if (abort_i) begin
          abort_flag_next = 1'b1;
          state_next      = SchDone;
        end else if (phase_reg) begin
          if (count_reg != '0) count_next = count_reg - CountWidth'(1);
          else                 state_next = SchDone;
        end
      end
      SchDone: begin
        done_o     = 1'b1;
        state_next = SchIdle;
      end
      default: state_next = SchIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= SchIdle;
      ptr_reg        <= '0;
      grant_id_reg   <= '0;
      count_reg      <= '0;
      param_sel_reg  <= '0;
      phase_reg      <= 1'b0;
      abort_flag_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      grant_id_reg   <= grant_id_next;
      count_reg      <= count_next;
      param_sel_reg  <= param_sel_next;
      phase_reg      <= phase_next;
      abort_flag_reg <= abort_flag_next;
      err_reg        <= err_next;
    end
  end

  assign busy_o       = (state_reg != SchIdle);
  assign grant_id_o   = busy_o ? grant_id_reg : '0;
  assign done_id_o    = done_o ? grant_id_reg : '0;
  assign done_abort_o = done_o && abort_flag_reg;
  assign err_o        = err_reg;

`ifdef TINY_NN_SCHED_PERF_EN
  logic [31:0] perf_busy_reg;
  logic [15:0] perf_jobs_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_busy_reg <= '0;
      perf_jobs_reg <= '0;
    end else begin
      if (busy_o && !(&perf_busy_reg))                    perf_busy_reg <= perf_busy_reg + 32'd1;
      if (done_o && !abort_flag_reg && !(&perf_jobs_reg)) perf_jobs_reg <= perf_jobs_reg + 16'd1;
    end
  end

  assign perf_busy_o = perf_busy_reg;
  assign perf_jobs_o = perf_jobs_reg;
`else
  assign perf_busy_o = '0;
  assign perf_jobs_o = '0;
`endif
endmodule

// File: tb/tb_tiny_nn_job_sched.sv
// Randomized bench for tiny_nn_job_sched against a latency-arithmetic reference model.
module tb_tiny_nn_job_sched;
  import tiny_nn_pkg::*;

  localparam int NR  = 2;
  localparam int CW  = 12;
  localparam int VAW = 4;
  localparam int VAS = VAW * 2;
  localparam int IW  = 1;

  typedef struct {
    logic [3:0] op;
    int         count;
  } desc_t;

  logic clk = 1'b0;
  logic rst;
  logic abort;
  always #5 clk = ~clk;

  tiny_nn_job_sched_if #(.NumReq(NR), .CountWidth(CW)) sched_if ();

  logic           param_req, mul_row_sel, mul_en, acc_en, busy, done, done_abort, err;
  logic [VAS-1:0] param_write;
  logic [1:0]     val_shift;
  logic [IW-1:0]  grant_id, done_id;
  logic [31:0]    perf_busy;
  logic [15:0]    perf_jobs;

  tiny_nn_job_sched #(.NumReq(NR), .CountWidth(CW), .ValArrayWidth(VAW), .ValArrayHeight(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_if          (sched_if),
    .abort_i         (abort),
    .param_req_o     (param_req),
    .param_write_o   (param_write),
    .val_shift_o     (val_shift),
    .mul_row_sel_o   (mul_row_sel),
    .mul_en_o        (mul_en),
    .accumulate_en_o (acc_en),
    .busy_o          (busy),
    .grant_id_o      (grant_id),
    .done_o          (done),
    .done_id_o       (done_id),
    .done_abort_o    (done_abort),
    .err_o           (err),
    .perf_busy_o     (perf_busy),
    .perf_jobs_o     (perf_jobs)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  desc_t q0[$];
  desc_t q1[$];

  // Reference model: one job described by its accept cycle and completion cycle.
  bit m_busy;
  bit m_ab;
  int m_t, m_done_cyc, m_id, m_ptr, m_err_cyc, m_pbusy, m_pjobs;
  bit push_en, abort_en, rst_en;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ab = 0; m_ptr = 0; m_err_cyc = -1; m_pbusy = 0; m_pjobs = 0;
    m_t = 0; m_done_cyc = 0; m_id = 0;
  endtask

  function automatic desc_t rand_desc();
    desc_t d;
    logic [3:0] o;
    if ($urandom_range(0, 4) == 0) begin
      o = 4'($urandom_range(0, 15));
      if (o == CmdOpConvolve) o = CmdOpNop;
      d.op = o;
    end else begin
      d.op = CmdOpConvolve;
    end
    d.count = $urandom_range(0, 6);
    return d;
  endfunction

  task automatic push(input int r, input logic [3:0] op, input int count);
    desc_t d;
    d.op = op;
    d.count = count;
    if (r == 0) q0.push_back(d); else q1.push_back(d);
  endtask

  task automatic drive_inputs();
    desc_t d;
    for (int r = 0; r < NR; r++) begin
      int sz = (r == 0) ? q0.size() : q1.size();
      if (sz > 0) d = (r == 0) ? q0[0] : q1[0];
      else        d = rand_desc();
      sched_if.req_valid[r]           = (sz > 0) && ($urandom_range(0, 5) != 0);
      sched_if.req_op[r*4 +: 4]       = d.op;
      sched_if.req_count[r*CW +: CW]  = CW'(d.count);
    end
    abort = abort_en && ($urandom_range(0, 39) == 0);
    rst   = rst_en && ($urandom_range(0, 599) == 0);
  endtask

  task automatic one_cycle();
    logic [NR-1:0]  e_ready;
    logic [VAS-1:0] e_pw;
    logic [1:0]     e_vs;
    logic           e_preq, e_mrs, e_men, e_acc, e_busy, e_done, e_dab, e_err;
    int             e_gid, e_did, win, k, p;
    bit             found;
    desc_t          d;

    @(negedge clk);
    e_ready = '0; e_pw = '0; e_vs = 2'b00;
    e_preq = 0; e_mrs = 0; e_men = 0; e_acc = 0; e_busy = 0; e_done = 0; e_dab = 0;
    e_gid = 0; e_did = 0; win = 0; found = 0;
    if (!m_busy && !rst) begin
      for (int j = 0; j < NR; j++) begin
        int r = (m_ptr + j) % NR;
        if (!found && sched_if.req_valid[r]) begin
          found = 1;
          win = r;
        end
      end
      if (found) e_ready[win] = 1'b1;
    end
    if (m_busy) begin
      e_busy = 1;
      e_gid  = m_id;
      k = cyc - m_t;
      if (cyc == m_done_cyc) begin
        e_done = 1; e_did = m_id; e_dab = m_ab;
      end else if (k <= VAS) begin
        e_pw = VAS'(1) << (k - 1);
        e_preq = 1;
      end else begin
        p = (k - VAS - 1) % 2;
        e_vs = {p[0], ~p[0]}; e_mrs = p[0]; e_men = 1; e_acc = p[0];
      end
    end
    e_err = (cyc == m_err_cyc);

    check_eq("req_ready", 32'(sched_if.req_ready), 32'(e_ready));
    check_eq("param_req", 32'(param_req), 32'(e_preq));
    check_eq("param_write", 32'(param_write), 32'(e_pw));
    check_eq("val_shift", 32'(val_shift), 32'(e_vs));
    check_eq("mul_row_sel", 32'(mul_row_sel), 32'(e_mrs));
    check_eq("mul_en", 32'(mul_en), 32'(e_men));
    check_eq("accumulate_en", 32'(acc_en), 32'(e_acc));
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("grant_id", 32'(grant_id), 32'(e_gid));
    check_eq("done", 32'(done), 32'(e_done));
    check_eq("done_id", 32'(done_id), 32'(e_did));
    check_eq("done_abort", 32'(done_abort), 32'(e_dab));
    check_eq("err", 32'(err), 32'(e_err));
`ifdef TINY_NN_SCHED_PERF_EN
    check_eq("perf_busy", perf_busy, 32'(m_pbusy));
    check_eq("perf_jobs", 32'(perf_jobs), 32'(m_pjobs));
`else
    check_eq("perf_busy", perf_busy, 32'd0);
    check_eq("perf_jobs", 32'(perf_jobs), 32'd0);
`endif

    if (rst) begin
      $display("reset cyc=%0d", cyc);
      model_reset();
    end else begin
      if (m_busy) m_pbusy++;
      if (m_busy && cyc == m_done_cyc) begin
        $display("done req%0d abort=%0d cyc=%0d", m_id, m_ab, cyc);
        m_busy = 0;
        if (!m_ab) m_pjobs++;
      end else if (m_busy && abort) begin
        m_done_cyc = cyc + 1;
        m_ab = 1;
      end
      if (found) begin
        d = (win == 0) ? q0.pop_front() : q1.pop_front();
        m_ptr = (win + 1) % NR;
        $display("accept req%0d op=%0h count=%0d cyc=%0d", win, d.op, d.count, cyc);
        if (d.op == CmdOpConvolve) begin
          m_busy = 1; m_ab = 0; m_id = win; m_t = cyc;
          m_done_cyc = cyc + VAS + 2 * (d.count + 1) + 1;
        end else begin
          m_err_cyc = cyc + 1;
        end
      end
    end

    if (push_en) begin
      if ($urandom_range(0, 7) == 0 && q0.size() < 3) q0.push_back(rand_desc());
      if ($urandom_range(0, 7) == 0 && q1.size() < 3) q1.push_back(rand_desc());
    end

    @(posedge clk);
    cyc++;
    #1;
    drive_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) one_cycle();
  endtask

  initial begin
    push_en = 0; abort_en = 0; rst_en = 0;
    sched_if.req_valid = '0;
    sched_if.req_op    = '0;
    sched_if.req_count = '0;
    abort = 0;
    rst   = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 0;

    run(4);
    push(0, CmdOpConvolve, 3);
    run(30);
    push(0, CmdOpConvolve, 0);
    push(1, CmdOpConvolve, 2);
    push(0, CmdOpConvolve, 1);
    run(60);
    push(1, CmdOpLoadParam, 5);
    push(0, CmdOpReadAcc, 1);
    run(20);
    push(1, CmdOpConvolve, (1 << CW) - 1);
    run(2 * (1 << CW) + VAS + 20);

    push_en = 1; abort_en = 1; rst_en = 1;
    run(4000);

    push_en = 0; abort_en = 0; rst_en = 0;
    run(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
